// File: rtl/scr1_cg_ctrl.sv
// -----------------------------------------------------------------------------
// scr1_cg_ctrl
// Clock-gate sequencer for one gated core domain. Runs on the free-running
// clock and decides when the clock-gate enable of the domain may drop:
// after a qualified sleep request has held for an idle window, the domain is
// gated; on wake it is ungated and given a settle window before wake_done.
// Cycles spent gated are accumulated in a saturating statistics counter.
//
// Ports:
//   clk           free-running (ungated) core clock
//   rst_n         asynchronous active-low reset
//   test_mode     DFT mode, forces RUN and inhibits gating
//   core_busy     domain has outstanding activity
//   sleep_req     level request to gate the domain clock
//   wake_req      level wake event
//   sleep_cnt_clr synchronous clear of sleep_cnt
//   clk_en        clock-gate enable, 1 = domain clocked
//   sleep_ack     1 while the domain clock is gated
//   wake_done     one-cycle pulse, domain clock stable after wake
//   sleep_cnt     saturating count of cycles spent gated
// -----------------------------------------------------------------------------
module scr1_cg_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic             core_busy,
  input  logic             sleep_req,
  input  logic             wake_req,
  input  logic             sleep_cnt_clr,
  output logic             clk_en,
  output logic             sleep_ack,
  output logic             wake_done,
  output logic [CNT_W-1:0] sleep_cnt
);

  localparam int MAX_C  = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_CW = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

  // The window counters expire on the cycle they read zero, so a window of
  // N cycles is loaded with N-1. This makes gating land exactly
  // IDLE_CYCLES+1 cycles after the first qualifying RUN cycle.
  localparam logic [CNT_CW-1:0] IDLE_LOAD =
    (IDLE_CYCLES > 0) ? CNT_CW'(IDLE_CYCLES - 1) : CNT_CW'(0);
  localparam logic [CNT_CW-1:0] WAKE_LOAD =
    (WAKE_CYCLES > 0) ? CNT_CW'(WAKE_CYCLES - 1) : CNT_CW'(0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_CW-1:0]  cnt_q, cnt_d;
  logic               clk_en_q, clk_en_d;
  logic               sleep_ack_q, sleep_ack_d;
  logic               wake_done_q, wake_done_d;
  logic [CNT_W-1:0]   sleep_cnt_q, sleep_cnt_d;
  logic               sleep_qual;

  assign sleep_qual = sleep_req & ~core_busy & ~wake_req;

  // Next-state, window counter and wake pulse decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wake_done_d = 1'b0;
    if (test_mode) begin
      state_d = ST_RUN;
      cnt_d   = CNT_CW'(0);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sleep_qual) begin
            if (IDLE_CYCLES == 0) begin
              state_d = ST_SLEEP;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = IDLE_LOAD;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE: begin
          // Abort wins over expiry in the same cycle
          if (!sleep_qual) begin
            state_d = ST_RUN;
            cnt_d   = CNT_CW'(0);
          end else if (cnt_q == CNT_CW'(0)) begin
            state_d = ST_SLEEP;
          end else begin
            cnt_d = cnt_q - CNT_CW'(1);
          end
        end
        ST_SLEEP: begin
          if (wake_req || !sleep_req) begin
            if (WAKE_CYCLES == 0) begin
              state_d     = ST_RUN;
              wake_done_d = 1'b1;
            end else begin
              state_d = ST_WAKE;
              cnt_d   = WAKE_LOAD;
            end
          end else begin
            state_d = ST_SLEEP;
          end
        end
        ST_WAKE: begin
          if (cnt_q == CNT_CW'(0)) begin
            state_d     = ST_RUN;
            wake_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_CW'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_CW'(0);
        end
      endcase
    end
  end

  // Output decode from next state so the outputs come straight from flops
  always_comb begin
    clk_en_d    = (state_d != ST_SLEEP);
    sleep_ack_d = (state_d == ST_SLEEP);
  end

  // Gated-cycle statistics: clear beats increment, saturate at all-ones
  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (sleep_cnt_clr) begin
      sleep_cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_SLEEP) && !test_mode && !(&sleep_cnt_q)) begin
      sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
    end else begin
      sleep_cnt_d = sleep_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= CNT_CW'(0);
      clk_en_q    <= 1'b1;
      sleep_ack_q <= 1'b0;
      wake_done_q <= 1'b0;
      sleep_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      sleep_ack_q <= sleep_ack_d;
      wake_done_q <= wake_done_d;
      sleep_cnt_q <= sleep_cnt_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign sleep_ack = sleep_ack_q;
  assign wake_done = wake_done_q;
  assign sleep_cnt = sleep_cnt_q;

endmodule
